// File: rtl/gw_gfx_pkg.sv
// Shared graphics constants for the VGA draw path: framebuffer geometry,
// blit FSM state encodings and named colours.
package gw_gfx_pkg;

    localparam int GfxXW     = 9;
    localparam int GfxYW     = 8;
    localparam int GfxColorW = 3;
    localparam int GfxXMax   = 320;
    localparam int GfxYMax   = 240;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRun    = 2'd1;
    localparam logic [1:0] StDrain  = 2'd2;
    localparam logic [1:0] StFinish = 2'd3;

    localparam logic [GfxColorW-1:0] ColourBlack = 3'b000;
    localparam logic [GfxColorW-1:0] ColourWhite = 3'b111;

endpackage

// File: rtl/sprite_scan_counter.sv
// Raster scan over a w x h sprite: column/row position plus the linear ROM
// address, advanced by increment so no multiplier is needed.
module sprite_scan_counter #(
    parameter int ADDR_W = 14,
    parameter int DIM_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    input  logic [DIM_W-1:0]  w,
    input  logic [DIM_W-1:0]  h,
    output logic [DIM_W-1:0]  col,
    output logic [DIM_W-1:0]  row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic col_end;

    assign col_end = (col == w - DIM_W'(1));
    assign last    = col_end && (row == h - DIM_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (clear) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (col_end) begin
                col <= '0;
                row <= row + DIM_W'(1);
            end else begin
                col <= col + DIM_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Copies a 1-bit sprite from a registered ROM into the framebuffer as plot
// writes with clipping and transparency. Horizontal flip needs SPRITE_MIRROR_EN.
module sprite_blitter
    import gw_gfx_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DIM_W   = 8,
    parameter int X_W     = GfxXW,
    parameter int Y_W     = GfxYW,
    parameter int COLOR_W = GfxColorW,
    parameter int X_MAX   = GfxXMax,
    parameter int Y_MAX   = GfxYMax
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [DIM_W-1:0]   spr_w,
    input  logic [DIM_W-1:0]   spr_h,
    input  logic [X_W-1:0]     base_x,
    input  logic [Y_W-1:0]     base_y,
    input  logic               draw,
    input  logic               mirror,
    input  logic [COLOR_W-1:0] foreground_colour,
    input  logic [COLOR_W-1:0] background_colour,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic               rom_q,
    output logic               busy,
    output logic               done,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               vga_plot
);

    logic [1:0]         state_q, state_d;
    logic [DIM_W-1:0]   w_q, h_q;
    logic [X_W-1:0]     bx_q;
    logic [Y_W-1:0]     by_q;
    logic [COLOR_W-1:0] colour_q;
    logic               valid_q, inb_q;
    logic [X_W-1:0]     px_q;
    logic [Y_W-1:0]     py_q;

    logic [DIM_W-1:0]   col, row, col_x;
    logic               last, zero_size, accept, scan_clear, scan_advance, in_bounds;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;

    assign zero_size    = (spr_w == '0) || (spr_h == '0);
    assign accept       = (state_q == StIdle) && start;
    assign scan_clear   = accept && !zero_size;
    assign scan_advance = (state_q == StRun) && !last;

    sprite_scan_counter #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .clear   (scan_clear),
        .advance (scan_advance),
        .w       (w_q),
        .h       (h_q),
        .col     (col),
        .row     (row),
        .addr    (rom_address),
        .last    (last)
    );

`ifdef SPRITE_MIRROR_EN
    logic mirror_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mirror_q <= 1'b0;
        end else if (accept) begin
            mirror_q <= mirror;
        end
    end

    assign col_x = mirror_q ? (w_q - DIM_W'(1) - col) : col;
`else
    logic unused_mirror;

    assign unused_mirror = mirror;
    assign col_x         = col;
`endif

    // One extra bit so off-screen sums compare correctly instead of wrapping.
    assign sum_x     = {1'b0, bx_q} + (X_W+1)'(col_x);
    assign sum_y     = {1'b0, by_q} + (Y_W+1)'(row);
    assign in_bounds = (sum_x < (X_W+1)'(X_MAX)) && (sum_y < (Y_W+1)'(Y_MAX));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = zero_size ? StFinish : StRun;
            StRun:    if (last) state_d = StDrain;
            StDrain:  state_d = StFinish;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            w_q      <= '0;
            h_q      <= '0;
            bx_q     <= '0;
            by_q     <= '0;
            colour_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                w_q      <= spr_w;
                h_q      <= spr_h;
                bx_q     <= base_x;
                by_q     <= base_y;
                colour_q <= draw ? foreground_colour : background_colour;
            end
        end
    end

    // Coordinates lag the ROM address by one cycle to line up with rom_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            inb_q   <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            valid_q <= (state_q == StRun);
            inb_q   <= in_bounds;
            px_q    <= sum_x[X_W-1:0];
            py_q    <= sum_y[Y_W-1:0];
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFinish);
    assign vga_x      = px_q;
    assign vga_y      = py_q;
    assign vga_colour = colour_q;
    assign vga_plot   = valid_q & rom_q & inb_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised bench for sprite_blitter against a plot-list model of the blit.
module tb_sprite_blitter;
    import gw_gfx_pkg::*;

`ifdef SPRITE_MIRROR_EN
    localparam bit MirrorOn = 1'b1;
`else
    localparam bit MirrorOn = 1'b0;
`endif
    localparam int Bound = 2000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  spr_w, spr_h;
    logic [8:0]  base_x;
    logic [7:0]  base_y;
    logic        draw, mirror;
    logic [2:0]  foreground_colour, background_colour;
    logic [13:0] rom_address;
    logic        rom_q = 1'b0;
    logic        busy, done;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    sprite_blitter dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .spr_w             (spr_w),
        .spr_h             (spr_h),
        .base_x            (base_x),
        .base_y            (base_y),
        .draw              (draw),
        .mirror            (mirror),
        .foreground_colour (foreground_colour),
        .background_colour (background_colour),
        .rom_address       (rom_address),
        .rom_q             (rom_q),
        .busy              (busy),
        .done              (done),
        .vga_x             (vga_x),
        .vga_y             (vga_y),
        .vga_colour        (vga_colour),
        .vga_plot          (vga_plot)
    );

    always #5 clock = ~clock;

    bit          rom_mem [0:1023];
    logic [19:0] obs_q [$];
    logic [19:0] exp_q [$];
    int          addr_log [0:63];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_seen = 0;

    always @(posedge clock) rom_q <= rom_mem[rom_address[9:0]];

    always @(negedge clock) begin
        if (vga_plot === 1'b1) obs_q.push_back({vga_x, vga_y, vga_colour});
        if (done === 1'b1) done_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected plot list: every set bit in raster order, placed and clipped.
    task automatic model_blit(input int w, input int h, input int bx, input int by,
                              input int colour, input bit mir);
        int x, y;
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (rom_mem[r * w + c]) begin
                    x = bx + (mir ? (w - 1 - c) : c);
                    y = by + r;
                    if (x < GfxXMax && y < GfxYMax)
                        exp_q.push_back({9'(x), 8'(y), 3'(colour)});
                end
            end
        end
    endtask

    task automatic compare_plots(input string tag);
        check_eq($sformatf("%s_nplots", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_pix%0d", tag, i), obs_q[i], exp_q[i]);
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'($urandom_range(0, 1));
    endtask

    // Runs one blit; returns at the negedge where done is seen (start left high if hold).
    task automatic run_blit(input string tag, input int w, input int h, input int bx,
                            input int by, input bit drw, input int fg, input int bg,
                            input bit mir, input bit hold);
        int k, busy_cnt, n, addr0;
        bit addr_still;
        n = w * h;
        model_blit(w, h, bx, by, drw ? fg : bg, MirrorOn && mir);
        @(negedge clock);
        obs_q.delete();
        spr_w = 8'(w); spr_h = 8'(h); base_x = 9'(bx); base_y = 8'(by);
        draw = drw; mirror = mir; foreground_colour = 3'(fg); background_colour = 3'(bg);
        start = 1'b1;
        addr0 = int'(rom_address);
        @(negedge clock);
        if (!hold) begin
            start = 1'b0;
            spr_w = 8'($urandom); spr_h = 8'($urandom); base_x = 9'($urandom);
            base_y = 8'($urandom); draw = 1'($urandom); mirror = 1'($urandom);
            foreground_colour = 3'($urandom); background_colour = 3'($urandom);
        end
        k = 0;
        busy_cnt = 0;
        addr_still = 1'b1;
        while (done !== 1'b1 && k < Bound) begin
            if (k < 64) addr_log[k] = int'(rom_address);
            if (int'(rom_address) != addr0) addr_still = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            @(negedge clock);
            k++;
        end
        if (k >= Bound) begin
            check_eq($sformatf("%s_timeout", tag), 32'(done), 32'd1);
            return;
        end
        if (busy === 1'b1) busy_cnt++;
        // Latency counted in cycles from the start-sampling edge to the end of the done cycle.
        check_eq($sformatf("%s_latency", tag), k + 1, (n == 0) ? 1 : n + 2);
        check_eq($sformatf("%s_busy_cycles", tag), busy_cnt, (n == 0) ? 1 : n + 2);
        if (n == 0) check_eq($sformatf("%s_addr_still", tag), 32'(addr_still), 32'd1);
        compare_plots(tag);
    endtask

    initial begin
        int w, h, bx, by, k, done_before;
        reset = 1'b1; start = 1'b0; spr_w = '0; spr_h = '0; base_x = '0; base_y = '0;
        draw = 1'b0; mirror = 1'b0; foreground_colour = '0; background_colour = '0;
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_plot", 32'(vga_plot), 0);
        check_eq("rst_addr", 32'(rom_address), 0);
        check_eq("rst_xycol", {vga_x, vga_y, vga_colour}, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // 3x2 sprite, rows 101 / 011
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'b0;
        rom_mem[0] = 1; rom_mem[2] = 1; rom_mem[4] = 1; rom_mem[5] = 1;
        run_blit("draw3x2", 3, 2, 10, 20, 1'b1, 7, 5, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) check_eq("draw3x2_addr", addr_log[i], i);
        if (obs_q.size() > 0) check_eq("draw3x2_first", obs_q[0], {9'd10, 8'd20, ColourWhite});
        run_blit("erase3x2", 3, 2, 10, 20, 1'b0, 7, 0, 1'b0, 1'b0);

        run_blit("zero_w", 0, 5, 40, 40, 1'b1, 3, 1, 1'b0, 1'b0);
        run_blit("zero_h", 6, 0, 40, 40, 1'b1, 3, 1, 1'b0, 1'b0);

        // Clipping at the right and bottom edges
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'b1;
        run_blit("clip_y239", 4, 1, 318, 239, 1'b1, 6, 0, 1'b0, 1'b0);
        run_blit("clip_y240", 4, 1, 318, 240, 1'b1, 6, 0, 1'b0, 1'b0);
        run_blit("clip_y100", 4, 1, 318, 100, 1'b1, 6, 0, 1'b0, 1'b0);

        // Start held through a 2x2 blit re-triggers only after FINISH
        fill_rom();
        run_blit("hold1", 2, 2, 30, 30, 1'b1, 2, 0, 1'b0, 1'b1);
        @(negedge clock);
        check_eq("hold_idle_gap", 32'(busy), 0);
        @(negedge clock);
        check_eq("hold_rebusy", 32'(busy), 1);
        check_eq("hold_readdr", 32'(rom_address), 0);
        obs_q.delete();
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < Bound) begin
            @(negedge clock);
            k++;
        end
        check_eq("hold2_done", 32'(done), 1);
        compare_plots("hold2");

        // Reset mid-RUN of a 4x4 all-ones blit
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'b1;
        @(negedge clock);
        spr_w = 8'd4; spr_h = 8'd4; base_x = 9'd50; base_y = 8'd50; draw = 1'b1;
        foreground_colour = 3'd5; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("mid_plot", 32'(vga_plot), 1);
        check_eq("mid_busy", 32'(busy), 1);
        done_before = done_seen;
        #2 reset = 1'b1;
        #1;
        check_eq("async_plot", 32'(vga_plot), 0);
        check_eq("async_busy", 32'(busy), 0);
        check_eq("async_done", 32'(done), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        check_eq("no_done_after_rst", done_seen, done_before);
        fill_rom();
        run_blit("post_rst", 4, 4, 60, 70, 1'b1, 4, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) check_eq("post_rst_addr", addr_log[i], i);

`ifdef SPRITE_MIRROR_EN
        for (int i = 0; i < 1024; i++) rom_mem[i] = 1'b0;
        rom_mem[0] = 1'b1;
        run_blit("mirror3x1", 3, 1, 5, 9, 1'b1, 7, 0, 1'b1, 1'b0);
        if (obs_q.size() > 0) check_eq("mirror_x", 32'(obs_q[0][19:11]), 7);
`endif

        for (int t = 0; t < 30; t++) begin
            fill_rom();
            w  = $urandom_range(0, 12);
            h  = $urandom_range(0, 8);
            bx = $urandom_range(0, 1) ? $urandom_range(0, 511) : $urandom_range(305, 322);
            by = $urandom_range(0, 1) ? $urandom_range(0, 255) : $urandom_range(230, 242);
            run_blit($sformatf("rand%0d", t), w, h, bx, by, 1'($urandom), $urandom_range(0, 7),
                     $urandom_range(0, 7), 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
